// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage core.
// Detects load-use hazards, selects EX-stage forwarding sources, freezes the
// front of the pipe while a multi-cycle op occupies EX, and squashes fetched
// instructions after a taken branch (optionally for a few extra cycles).
// Control outputs are combinational from the FSM state and the pipeline
// register fields; only the state, the down-counter and the stall counter
// are registered.
module hazard_ctrl #(
    parameter int REG_W       = 3,
    parameter int MC_LAT      = 4,
    parameter int FLUSH_EXTRA = 0,
    parameter int ZERO_REG    = 1,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_ex_mem_read,
    input  logic [REG_W-1:0]  id_ex_rd,
    input  logic              id_ex_mc_start,
    input  logic [REG_W-1:0]  id_ex_rs,
    input  logic [REG_W-1:0]  id_ex_rt,
    input  logic [REG_W-1:0]  if_id_rs,
    input  logic [REG_W-1:0]  if_id_rt,
    input  logic              ex_mem_reg_write,
    input  logic [REG_W-1:0]  ex_mem_rd,
    input  logic              mem_wb_reg_write,
    input  logic [REG_W-1:0]  mem_wb_rd,
    input  logic              branch_taken,
    output logic              stall,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mc_busy,
    output logic [PERF_W-1:0] stall_cnt
);

    // The down-counter is shared by the freeze and the extra-flush phases,
    // so it is sized for whichever of the two needs the larger preload.
    localparam int CNT_MAX = (MC_LAT > FLUSH_EXTRA) ? MC_LAT : FLUSH_EXTRA;
    localparam int CNT_W   = ($clog2(CNT_MAX + 1) < 1) ? 1 : $clog2(CNT_MAX + 1);

    // Preload values; guarded so that degenerate parameter choices never
    // produce a negative constant.
    localparam logic [CNT_W-1:0] MC_LOAD    = (MC_LAT >= 2) ? CNT_W'(MC_LAT - 2) : '0;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = (FLUSH_EXTRA > 0) ? CNT_W'(FLUSH_EXTRA - 1) : '0;
    localparam logic             MC_ENABLED = (MC_LAT >= 2);
    localparam logic             HAS_EXTRA  = (FLUSH_EXTRA > 0);
    localparam logic             ZERO_HARD  = (ZERO_REG != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic load_use_hit;
    logic freeze;
    logic lu_stall;

    // A destination register is a live producer unless it is the hardwired
    // zero register.
    function automatic logic live_reg(input logic [REG_W-1:0] r);
        return !(ZERO_HARD && (r == '0));
    endfunction

    // Forwarding select for one EX operand: the younger EX/MEM result beats
    // the older MEM/WB result when both target the same register.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_mem_reg_write && live_reg(ex_mem_rd) && (ex_mem_rd == src)) begin
            sel = 2'b10;
        end else if (mem_wb_reg_write && live_reg(mem_wb_rd) && (mem_wb_rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Raw load-use condition: a load in ID/EX feeds an instruction in IF/ID.
    always_comb begin
        load_use_hit = id_ex_mem_read && live_reg(id_ex_rd) &&
                       ((id_ex_rd == if_id_rs) || (id_ex_rd == if_id_rt));
    end

    // Operand forwarding runs every cycle regardless of FSM state.
    always_comb begin
        fwd_a = fwd_sel(id_ex_rs);
        fwd_b = fwd_sel(id_ex_rt);
    end

    // Next-state logic plus the freeze / load-use / flush decisions.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        freeze      = 1'b0;
        lu_stall    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        case (state)
            IDLE: begin
                if (branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (HAS_EXTRA) begin
                        state_next = FLUSH;
                        cnt_next   = FLUSH_LOAD;
                    end
                end else if (id_ex_mc_start && MC_ENABLED) begin
                    freeze     = 1'b1;
                    state_next = MC_WAIT;
                    cnt_next   = MC_LOAD;
                end else if (load_use_hit) begin
                    lu_stall = 1'b1;
                end
            end

            MC_WAIT: begin
                if (cnt != '0) begin
                    freeze   = 1'b1;
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    state_next = IDLE;
                    if (load_use_hit) begin
                        lu_stall = 1'b1;
                    end
                end
            end

            FLUSH: begin
                if_id_flush = 1'b1;
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        if (lu_stall) begin
            id_ex_flush = 1'b1;
        end
    end

    // Pipeline enables derived from the freeze and load-use decisions.
    always_comb begin
        stall        = freeze || lu_stall;
        pc_write     = !(freeze || lu_stall);
        if_id_write  = !(freeze || lu_stall);
        id_ex_write  = !freeze;
        ex_mem_flush = freeze;
        mc_busy      = (state == MC_WAIT);
    end

    // FSM state and shared down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {PERF_W{1'b1}})) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule
